pipelined_adder_subtractor: RTL

//  - Parametrised N-bit adder/subtractor: successor to the 4-bit ripple adder/subtractor.
//  - Splits the carry chain into CHUNK-bit ripple slices, with one register stage per slice.
//  - Uses a valid/ready handshake on both sides and supports full-throughput streaming with backpressure.
//  - Sits between operand sources and the ALU result bus.
//  - Flags unsigned carry/borrow (cout) and signed overflow (ovf).
//

---
 rtl/pipelined_adder_subtractor_pkg.sv | 12 +
 rtl/addsub_slice.sv | 31 +++
 rtl/full_adder_nodelay.sv | 13 +
 rtl/pipelined_adder_subtractor.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pipelined_adder_subtractor_pkg.sv
// Shared operation encoding and default geometry for the pipelined adder/subtractor.
package pipelined_adder_subtractor_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple slice; also exposes the carry into its top bit
// so the final slice can derive signed overflow.
module addsub_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder_nodelay u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_c[i]),
            .o_s (o_sum[i]),
            .o_c (w_c[i+1])
        );
    end

    assign o_cout  = w_c[CHUNK];
    assign o_c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/full_adder_nodelay.sv
// One-bit full adder cell used to build the ripple slices.
module full_adder_nodelay (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_adder_subtractor.sv
// N-bit adder/subtractor with one register stage per CHUNK-bit ripple slice and
// a single global advance enable shared by every stage.
module pipelined_adder_subtractor
    import pipelined_adder_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             w_advance;
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_sub     = (addsub_op_e'(op) == OP_SUB);
    assign w_b_eff   = b ^ {WIDTH{w_sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * CHUNK;
        localparam int REM = WIDTH - LO;  // operand bits not yet summed on entry to this stage

        logic [REM-1:0]      w_a_src;
        logic [REM-1:0]      w_b_src;
        logic                w_cin;
        logic                w_vin;
        logic [CHUNK-1:0]    w_sum;
        logic                w_cout;
        logic [LO+CHUNK-1:0] w_sum_next;
        logic                r_valid;
        logic                r_carry;
        logic [LO+CHUNK-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_a_src    = a;
            assign w_b_src    = w_b_eff;
            assign w_cin      = w_sub;
            assign w_vin      = in_valid;
            assign w_sum_next = w_sum;
        end else begin : g_src
            assign w_a_src    = g_stage[k-1].g_skew.r_a_hi;
            assign w_b_src    = g_stage[k-1].g_skew.r_b_hi;
            assign w_cin      = g_stage[k-1].r_carry;
            assign w_vin      = g_stage[k-1].r_valid;
            assign w_sum_next = {w_sum, g_stage[k-1].r_sum};
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid <= 1'b0;
            end else if (w_advance) begin
                r_valid <= w_vin;
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic w_c_msb;
            logic r_ovf;

            addsub_slice #(.CHUNK(CHUNK)) u_slice (
                .i_a     (w_a_src[CHUNK-1:0]),
                .i_b     (w_b_src[CHUNK-1:0]),
                .i_cin   (w_cin),
                .o_sum   (w_sum),
                .o_cout  (w_cout),
                .o_c_msb (w_c_msb)
            );

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sum   <= '0;
                    r_carry <= 1'b0;
                    r_ovf   <= 1'b0;
                end else if (w_advance) begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_cout;
                    r_ovf   <= w_c_msb ^ w_cout;
                end
            end
        end else begin : g_skew
            logic                   w_c_msb_unused;
            logic [REM-CHUNK-1:0]   r_a_hi;
            logic [REM-CHUNK-1:0]   r_b_hi;

            addsub_slice #(.CHUNK(CHUNK)) u_slice (
                .i_a     (w_a_src[CHUNK-1:0]),
                .i_b     (w_b_src[CHUNK-1:0]),
                .i_cin   (w_cin),
                .o_sum   (w_sum),
                .o_cout  (w_cout),
                .o_c_msb (w_c_msb_unused)
            );

            // Datapath of inner stages is don't-care while invalid, so no reset here.
            always_ff @(posedge clk) begin
                if (w_advance) begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_cout;
                    r_a_hi  <= w_a_src[REM-1:CHUNK];
                    r_b_hi  <= w_b_src[REM-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign s         = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_carry;
    assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule
